// File: rtl/online_div_arbiter_if.sv
// Bundle of requester-side and divider-side handshake signals for the online divider arbiter.
interface online_div_arbiter_if #(parameter int CNT_W = 4);
  logic [1:0]       req;
  logic [1:0]       x0;
  logic [1:0]       d0;
  logic [1:0]       x1;
  logic [1:0]       d1;
  logic [1:0]       in_vld;
  logic [1:0]       in_rdy;
  logic [1:0]       q;
  logic [1:0]       q_vld;
  logic [1:0]       q_rdy;
  logic [1:0]       div_x;
  logic [1:0]       div_d;
  logic             div_x_vld;
  logic             div_d_vld;
  logic             div_x_rdy;
  logic             div_d_rdy;
  logic [1:0]       div_q;
  logic             div_q_vld;
  logic             div_q_rdy;
  logic [1:0]       grant;
  logic [1:0]       job_done;
  logic             busy;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;

  modport slave (
    input  req, x0, d0, x1, d1, in_vld, q_rdy, div_x_rdy, div_d_rdy, div_q, div_q_vld,
    output in_rdy, q, q_vld, div_x, div_d, div_x_vld, div_d_vld, div_q_rdy,
           grant, job_done, busy, in_cnt, out_cnt
  );

  modport master (
    output req, x0, d0, x1, d1, in_vld, q_rdy, div_x_rdy, div_d_rdy, div_q, div_q_vld,
    input  in_rdy, q, q_vld, div_x, div_d, div_x_vld, div_d_vld, div_q_rdy,
           grant, job_done, busy, in_cnt, out_cnt
  );
endinterface

// File: rtl/online_div_arbiter.sv
// Arbitrates two requesters onto one online (digit-serial) divider, one full job at a time.
module online_div_arbiter #(
  parameter int DIGITS = 8,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  online_div_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_served_q, last_served_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             buf_full_q, buf_full_d;
  logic             x_taken_q, x_taken_d;
  logic             d_taken_q, d_taken_d;
  logic [1:0]       buf_x_q, buf_x_d;
  logic [1:0]       buf_d_q, buf_d_d;

  logic       g;
  logic       running;
  logic       in_rdy_g;
  logic       in_hs;
  logic       x_vld, d_vld;
  logic       x_hs, d_hs;
  logic       q_rdy_g;
  logic       q_hs;
  logic [1:0] sel_x, sel_d;

  assign g        = grant_q[1];
  assign running  = (state_q == RUN);
  assign sel_x    = g ? bus.x1 : bus.x0;
  assign sel_d    = g ? bus.d1 : bus.d0;
  assign in_rdy_g = running && !buf_full_q && (in_cnt_q < DIGITS_C);
  assign in_hs    = in_rdy_g && bus.in_vld[g];
  assign x_vld    = running && buf_full_q && !x_taken_q;
  assign d_vld    = running && buf_full_q && !d_taken_q;
  assign x_hs     = x_vld && bus.div_x_rdy;
  assign d_hs     = d_vld && bus.div_d_rdy;
  assign q_rdy_g  = running && bus.q_rdy[g];
  assign q_hs     = q_rdy_g && bus.div_q_vld;

  assign bus.in_rdy    = {2{in_rdy_g}} & grant_q;
  assign bus.q         = bus.div_q;
  assign bus.q_vld     = {2{running && bus.div_q_vld}} & grant_q;
  assign bus.div_q_rdy = q_rdy_g;
  assign bus.div_x     = buf_x_q;
  assign bus.div_d     = buf_d_q;
  assign bus.div_x_vld = x_vld;
  assign bus.div_d_vld = d_vld;
  assign bus.grant     = grant_q;
  assign bus.job_done  = {2{state_q == DONE}} & grant_q;
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.in_cnt    = in_cnt_q;
  assign bus.out_cnt   = out_cnt_q;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      last_served_q <= 1'b1;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      buf_full_q    <= 1'b0;
      x_taken_q     <= 1'b0;
      d_taken_q     <= 1'b0;
      buf_x_q       <= 2'b00;
      buf_d_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      buf_full_q    <= buf_full_d;
      x_taken_q     <= x_taken_d;
      d_taken_q     <= d_taken_d;
      buf_x_q       <= buf_x_d;
      buf_d_q       <= buf_d_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    buf_full_d    = buf_full_q;
    x_taken_d     = x_taken_q;
    d_taken_d     = d_taken_q;
    buf_x_d       = buf_x_q;
    buf_d_d       = buf_d_q;

    case (state_q)
      IDLE: begin
        // On a tie the requester not served last time wins.
        if (bus.req != 2'b00) begin
          if (bus.req == 2'b11) grant_d = last_served_q ? 2'b01 : 2'b10;
          else                  grant_d = bus.req;
          state_d    = RUN;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          buf_full_d = 1'b0;
          x_taken_d  = 1'b0;
          d_taken_d  = 1'b0;
        end
      end
      RUN: begin
        if (in_hs) begin
          buf_full_d = 1'b1;
          buf_x_d    = sel_x;
          buf_d_d    = sel_d;
          in_cnt_d   = in_cnt_q + ONE_C;
        end
        // x and d may be consumed on different cycles; the slot frees only once both are gone.
        if (buf_full_q) begin
          x_taken_d = x_taken_q || x_hs;
          d_taken_d = d_taken_q || d_hs;
          if ((x_taken_q || x_hs) && (d_taken_q || d_hs)) begin
            buf_full_d = 1'b0;
            x_taken_d  = 1'b0;
            d_taken_d  = 1'b0;
          end
        end
        if (q_hs) begin
          out_cnt_d = out_cnt_q + ONE_C;
          if ((out_cnt_q + ONE_C) == DIGITS_C) state_d = DONE;
        end
      end
      DONE: begin
        last_served_d = g;
        grant_d       = 2'b00;
        buf_full_d    = 1'b0;
        x_taken_d     = 1'b0;
        d_taken_d     = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_online_div_arbiter.sv
// Directed self-checking bench for online_div_arbiter with hand-computed expectations.
module tb_online_div_arbiter;

  logic clk;
  logic asyn_reset;
  int   tests;
  int   fails;
  int   acc;

  online_div_arbiter_if #(.CNT_W(4)) bus ();

  online_div_arbiter #(.DIGITS(8), .CNT_W(4)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] in_vld,
                               input logic [1:0] q_rdy, input logic x_rdy, input logic d_rdy,
                               input logic q_vld, input logic [1:0] dq);
    bus.req       = req;
    bus.in_vld    = in_vld;
    bus.q_rdy     = q_rdy;
    bus.div_x_rdy = x_rdy;
    bus.div_d_rdy = d_rdy;
    bus.div_q_vld = q_vld;
    bus.div_q     = dq;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    asyn_reset = 1'b1;
    bus.x0 = 2'b00; bus.d0 = 2'b00; bus.x1 = 2'b00; bus.d1 = 2'b00;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    tick(); tick();

    checkOutput("rst_grant", 32'(bus.grant), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_in_rdy", 32'(bus.in_rdy), 32'h0);
    checkOutput("rst_q_vld", 32'(bus.q_vld), 32'h0);
    checkOutput("rst_div_q_rdy", 32'(bus.div_q_rdy), 32'h0);
    checkOutput("rst_div_x_vld", 32'(bus.div_x_vld), 32'h0);
    checkOutput("rst_div_d_vld", 32'(bus.div_d_vld), 32'h0);
    checkOutput("rst_cnts", 32'({bus.in_cnt, bus.out_cnt}), 32'h0);
    checkOutput("rst_div_xd", 32'({bus.div_x, bus.div_d}), 32'h0);
    checkOutput("rst_job_done", 32'(bus.job_done), 32'h0);

    asyn_reset = 1'b0;
    tick();
    checkOutput("idle_no_q_ack", 32'(bus.div_q_rdy), 32'h0);

    // Tie after reset: requester 0 first.
    applyStimulus(2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("tie_grant0", 32'(bus.grant), 32'h1);
    checkOutput("run_busy", 32'(bus.busy), 32'h1);
    checkOutput("run_in_rdy0", 32'(bus.in_rdy), 32'h1);

    bus.x0 = 2'b01; bus.d0 = 2'b01;
    applyStimulus(2'b11, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 2'b10);
    checkOutput("q_pass", 32'(bus.q), 32'h2);
    checkOutput("q_vld_g0", 32'(bus.q_vld), 32'h1);
    checkOutput("div_q_rdy_run", 32'(bus.div_q_rdy), 32'h1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("job0_out_cnt", 32'(bus.out_cnt), 32'(i));
      tick();
    end
    checkOutput("done_job_done0", 32'(bus.job_done), 32'h1);
    checkOutput("done_out_cnt", 32'(bus.out_cnt), 32'h8);
    checkOutput("done_in_cnt", 32'(bus.in_cnt), 32'h4);
    checkOutput("done_in_rdy", 32'(bus.in_rdy), 32'h0);
    checkOutput("done_div_q_rdy", 32'(bus.div_q_rdy), 32'h0);

    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("idle_job_done", 32'(bus.job_done), 32'h0);
    checkOutput("idle_grant", 32'(bus.grant), 32'h0);
    checkOutput("idle_busy", 32'(bus.busy), 32'h0);
    tick();
    checkOutput("grant1", 32'(bus.grant), 32'h2);

    // Requester 1 streams operands with an always-ready divider.
    bus.x1 = 2'b01; bus.d1 = 2'b11;
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("in_rdy1", 32'(bus.in_rdy), 32'h2);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_rdy[1] && bus.in_vld[1]) acc++;
      tick();
      if (i == 0) begin
        checkOutput("cap_div_x", 32'(bus.div_x), 32'h1);
        checkOutput("cap_div_d", 32'(bus.div_d), 32'h3);
        checkOutput("cap_vlds", 32'({bus.div_x_vld, bus.div_d_vld}), 32'h3);
        checkOutput("full_in_rdy", 32'(bus.in_rdy), 32'h0);
      end
    end
    checkOutput("accepts", 32'(acc), 32'h8);
    checkOutput("in_cnt_cap", 32'(bus.in_cnt), 32'h8);
    checkOutput("in_rdy_cap", 32'(bus.in_rdy), 32'h0);

    // Quotient stalled by requester.
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_div_q_rdy", 32'(bus.div_q_rdy), 32'h0);
      checkOutput("stall_q_vld", 32'(bus.q_vld), 32'h2);
      tick();
    end
    checkOutput("stall_out_cnt", 32'(bus.out_cnt), 32'h0);
    checkOutput("stall_busy", 32'(bus.busy), 32'h1);
    applyStimulus(2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 2'b01);
    repeat (8) tick();
    checkOutput("done_job_done1", 32'(bus.job_done), 32'h2);
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    tick();
    checkOutput("grant0_b", 32'(bus.grant), 32'h1);

    // Divider d side three cycles late.
    bus.x0 = 2'b10; bus.d0 = 2'b01;
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    checkOutput("r1_vlds", 32'({bus.div_x_vld, bus.div_d_vld}), 32'h3);
    checkOutput("r1_div_x", 32'(bus.div_x), 32'h2);
    tick();
    checkOutput("r2_vlds", 32'({bus.div_x_vld, bus.div_d_vld}), 32'h1);
    tick();
    checkOutput("r3_d_vld", 32'(bus.div_d_vld), 32'h1);
    tick();
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("r4_d_vld", 32'(bus.div_d_vld), 32'h1);
    checkOutput("r4_in_rdy", 32'(bus.in_rdy), 32'h0);
    tick();
    checkOutput("r5_d_vld", 32'(bus.div_d_vld), 32'h0);
    checkOutput("r5_in_rdy", 32'(bus.in_rdy), 32'h1);
    checkOutput("r5_in_cnt", 32'(bus.in_cnt), 32'h1);
    applyStimulus(2'b01, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00);
    repeat (8) tick();
    checkOutput("done_job_done0_b", 32'(bus.job_done), 32'h1);

    applyStimulus(2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    tick();
    checkOutput("tie_grant1", 32'(bus.grant), 32'h2);

    // Reset in the middle of requester 1's job.
    applyStimulus(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 2'b11);
    checkOutput("q_pass1", 32'(bus.q), 32'h3);
    repeat (3) tick();
    checkOutput("mid_out_cnt", 32'(bus.out_cnt), 32'h3);
    checkOutput("mid_q_vld", 32'(bus.q_vld), 32'h2);
    #1;
    asyn_reset = 1'b1;
    #1;
    checkOutput("ar_grant", 32'(bus.grant), 32'h0);
    checkOutput("ar_busy", 32'(bus.busy), 32'h0);
    checkOutput("ar_out_cnt", 32'(bus.out_cnt), 32'h0);
    checkOutput("ar_q_vld", 32'(bus.q_vld), 32'h0);
    checkOutput("ar_div_q_rdy", 32'(bus.div_q_rdy), 32'h0);
    checkOutput("ar_job_done", 32'(bus.job_done), 32'h0);
    tick();
    asyn_reset = 1'b0;
    checkOutput("ar_hold_grant", 32'(bus.grant), 32'h0);
    tick();
    checkOutput("post_rst_grant", 32'(bus.grant), 32'h1);
    checkOutput("post_rst_job_done", 32'(bus.job_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/online_div_arbiter.md
ONLINE_DIV_ARBITER -- requirements
Module: online_div_arbiter

Interface
REQ-001 Parameter DIGITS, default 8, digits per division job (operand digits sent = quotient digits returned = DIGITS).
REQ-002 Parameter CNT_W, default 4, counter width; SHALL satisfy 2^CNT_W > DIGITS.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 asyn_reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-requester job request; bit i held high until job_done[i].
REQ-006 x0, d0, x1, d1  in  2 each  signed-digit operand digits from requester 0/1.
REQ-007 in_vld  in  2 / in_rdy  out  2  per-requester operand-digit handshake (x and d travel together).
REQ-008 q  out  2  quotient digit, shared by both requesters.
REQ-009 q_vld  out  2 / q_rdy  in  2  per-requester quotient handshake.
REQ-010 div_x, div_d  out  2 each / div_x_vld, div_d_vld  out  1 / div_x_rdy, div_d_rdy  in  1  operand ports to the divider.
REQ-011 div_q  in  2 / div_q_vld  in  1 / div_q_rdy  out  1  quotient port from the divider.
REQ-012 grant  out  2  registered, one-hot or zero; job_done  out  2  one-cycle pulse; busy  out  1  high in RUN/DONE.
REQ-013 in_cnt, out_cnt  out  CNT_W each  operand digits accepted / quotient digits delivered in current job.

Function
REQ-014 FSM states IDLE, RUN, DONE; a handshake completes on a cycle where vld and rdy are both high.
REQ-015 IDLE: if exactly one req bit high, grant it; if both high, grant the requester other than last_served; transition to RUN next cycle with in_cnt = out_cnt = 0; if none, stay in IDLE.
REQ-016 RUN, operand side: 1-entry holding buffer; in_rdy[g] = RUN and buffer empty and in_cnt < DIGITS; on handshake, capture x_g/d_g, set buffer full, in_cnt += 1.
REQ-017 Buffer full: div_x_vld high until x handshake, div_d_vld high until d handshake, tracked by independent taken flags; buffer empties (flags cleared) on the cycle the second of the two handshakes completes, including when both complete in the same cycle.
REQ-018 Buffer empty, or in IDLE/DONE: div_x_vld = div_d_vld = 0; div_x/div_d hold the buffer contents.
REQ-019 RUN, quotient side: q = div_q; q_vld[g] = div_q_vld; div_q_rdy = q_rdy[g]; non-granted q_vld bit = 0; out_cnt += 1 per handshake (pass-through, zero latency).
REQ-020 Operand and quotient handshakes in the same cycle both complete.
REQ-021 RUN -> DONE on the cycle out_cnt reaches DIGITS; in DONE: job_done[g] = 1, last_served <= g, grant <= 0, div_q_rdy = 0, in_rdy = 0; DONE -> IDLE after one cycle.
REQ-022 req[g] deasserted during RUN is ignored; job runs to completion. A new request is not granted until IDLE (one idle cycle minimum between jobs).
REQ-023 div_q_vld while not in RUN is not acknowledged (div_q_rdy = 0).
REQ-024 Counters never exceed DIGITS; no further in_rdy once in_cnt = DIGITS.

Reset
REQ-025 asyn_reset high, at any time including mid-job: state IDLE, grant = 0, job_done = 0, in_rdy = 0, q_vld = 0, div_x_vld = div_d_vld = 0, div_q_rdy = 0, busy = 0, in_cnt = out_cnt = 0, buffer empty, div_x = div_d = 0, last_served = 1 (requester 0 wins first tie).
REQ-026 In-flight job discarded; no job_done issued for it.

Verification
REQ-027 Reset, then req = 2'b11 -> grant = 2'b01 one cycle later; after DIGITS=8 quotient handshakes, job_done = 2'b01 for one cycle; next grant = 2'b10.
REQ-028 Single requester 1, div_x_rdy = div_d_rdy = 1 always -> in_rdy[1] accepts 8 digits then stays low; in_cnt = 8.
REQ-029 div_x_rdy high, div_d_rdy delayed 3 cycles -> div_x_vld drops after one cycle, div_d_vld held 4 cycles, in_rdy[g] low until d handshake.
REQ-030 q_rdy[g] = 0 for 5 cycles with div_q_vld = 1 -> div_q_rdy = 0, out_cnt unchanged, state stays RUN.
REQ-031 asyn_reset pulsed after 3 quotient digits of job for requester 1 -> all outputs at reset values, no job_done; with req = 2'b11 next grant = 2'b01.
